// File: rtl/aplic_msi_writer.sv
`default_nettype none
// ============================================================================
// Module   : aplic_msi_writer
// Brief    : Queues APLIC MSI messages in a small FIFO and issues each one as
//            a single-beat AXI4 write into the IMSIC interrupt-file region.
//            One write outstanding at a time, strict push order, entry popped
//            only when its B response arrives.
// Options  : MSI_ERR_CNT_EN - when defined, counts non-OKAY B responses and
//            records the address of the most recent failing message.
// Revision : 1.0 - initial release
// ============================================================================
module aplic_msi_writer #(
   parameter int DEPTH        = 4,
   parameter int ADDR_W       = 32,
   parameter int AXI_ID_WIDTH = 4,
   parameter int AXI_ID       = 0
) (
   input  logic                      i_clk,
   input  logic                      ni_rst,
   // MSI request side
   input  logic                      i_msi_valid,
   output logic                      o_msi_ready,
   input  logic [ADDR_W-1:0]         i_msi_addr,
   input  logic [31:0]               i_msi_data,
   // AXI write address channel
   output logic                      o_awvalid,
   input  logic                      i_awready,
   output logic [ADDR_W-1:0]         o_awaddr,
   output logic [AXI_ID_WIDTH-1:0]   o_awid,
   output logic [7:0]                o_awlen,
   output logic [2:0]                o_awsize,
   output logic [1:0]                o_awburst,
   // AXI write data channel
   output logic                      o_wvalid,
   input  logic                      i_wready,
   output logic [63:0]               o_wdata,
   output logic [7:0]                o_wstrb,
   output logic                      o_wlast,
   // AXI write response channel
   input  logic                      i_bvalid,
   output logic                      o_bready,
   input  logic [1:0]                i_bresp,
   // Status / telemetry
   output logic [$clog2(DEPTH):0]    o_count,
   output logic                      o_busy,
   output logic [7:0]                o_err_cnt,
   output logic [ADDR_W-1:0]         o_err_addr
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   // FIFO storage and pointers
   logic [ADDR_W-1:0] addr_mem [DEPTH];
   logic [31:0]       data_mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]  count_q;

   // FSM and AXI output registers
   state_e            state_q, state_d;
   logic              awvalid_q, awvalid_d;
   logic              wvalid_q, wvalid_d;
   logic              aw_done_q, aw_done_d;
   logic              w_done_q, w_done_d;
   logic [ADDR_W-1:0] awaddr_q;
   logic [63:0]       wdata_q;
   logic [7:0]        wstrb_q;

   logic              push, pop, load;
   logic              aw_hs, w_hs;
   logic              fifo_empty;
   logic [ADDR_W-1:0] head_addr;
   logic [31:0]       head_data;

   assign fifo_empty  = (count_q == '0);
   assign o_msi_ready = (count_q != CNT_W'(DEPTH));
   assign push        = i_msi_valid && o_msi_ready;
   assign aw_hs       = awvalid_q && i_awready;
   assign w_hs        = wvalid_q && i_wready;

   // When the FIFO is empty the entry being pushed this cycle is the head, so
   // it is forwarded straight into the output registers to save a cycle.
   assign head_addr = fifo_empty ? i_msi_addr : addr_mem[rd_ptr_q];
   assign head_data = fifo_empty ? i_msi_data : data_mem[rd_ptr_q];

   // Next-state and channel-valid logic for the single-outstanding write FSM
   always_comb begin
      state_d   = state_q;
      awvalid_d = awvalid_q;
      wvalid_d  = wvalid_q;
      aw_done_d = aw_done_q;
      w_done_d  = w_done_q;
      load      = 1'b0;
      pop       = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!fifo_empty || push) begin
               load      = 1'b1;
               awvalid_d = 1'b1;
               wvalid_d  = 1'b1;
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
               state_d   = ST_SEND;
            end
         end
         ST_SEND: begin
            if (aw_hs) begin
               awvalid_d = 1'b0;
               aw_done_d = 1'b1;
            end
            if (w_hs) begin
               wvalid_d = 1'b0;
               w_done_d = 1'b1;
            end
            if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
               state_d = ST_RESP;
            end
         end
         ST_RESP: begin
            if (i_bvalid) begin
               pop     = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d   = ST_IDLE;
            awvalid_d = 1'b0;
            wvalid_d  = 1'b0;
         end
      endcase
   end

   // FSM state, output payload registers, FIFO pointers and occupancy
   always_ff @(posedge i_clk) begin
      if (!ni_rst) begin
         state_q   <= ST_IDLE;
         awvalid_q <= 1'b0;
         wvalid_q  <= 1'b0;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
         awaddr_q  <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
      end else begin
         state_q   <= state_d;
         awvalid_q <= awvalid_d;
         wvalid_q  <= wvalid_d;
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
         if (load) begin
            awaddr_q <= head_addr;
            wdata_q  <= {head_data, head_data};
            wstrb_q  <= head_addr[2] ? 8'hF0 : 8'h0F;
         end
         if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         case ({push, pop})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // FIFO storage write; contents are don't-care until a pointer covers them
   always_ff @(posedge i_clk) begin
      if (push) begin
         addr_mem[wr_ptr_q] <= i_msi_addr;
         data_mem[wr_ptr_q] <= i_msi_data;
      end
   end

   assign o_awvalid = awvalid_q;
   assign o_awaddr  = awaddr_q;
   assign o_awid    = AXI_ID_WIDTH'(AXI_ID);
   assign o_awlen   = 8'd0;
   assign o_awsize  = 3'b010;
   assign o_awburst = 2'b01;
   assign o_wvalid  = wvalid_q;
   assign o_wdata   = wdata_q;
   assign o_wstrb   = wstrb_q;
   assign o_wlast   = 1'b1;
   assign o_bready  = (state_q == ST_RESP);
   assign o_count   = count_q;
   assign o_busy    = !fifo_empty || (state_q != ST_IDLE);

`ifdef MSI_ERR_CNT_EN
   logic [7:0]        err_cnt_q;
   logic [ADDR_W-1:0] err_addr_q;

   // Saturating count of failed writes plus address of the latest failure
   always_ff @(posedge i_clk) begin
      if (!ni_rst) begin
         err_cnt_q  <= '0;
         err_addr_q <= '0;
      end else if (pop && (i_bresp != 2'b00)) begin
         if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
         err_addr_q <= awaddr_q;
      end
   end

   assign o_err_cnt  = err_cnt_q;
   assign o_err_addr = err_addr_q;
`else
   // Failed writes are dropped silently; the response code is not needed.
   logic unused_bresp;
   assign unused_bresp = ^i_bresp;
   assign o_err_cnt    = 8'd0;
   assign o_err_addr   = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_aplic_msi_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_aplic_msi_writer
// Brief    : Self-checking bench for aplic_msi_writer: vector table of single
//            MSIs, hand sequences for back-pressure / ordering / reset, and a
//            queue scoreboard checking every AW, W and B handshake.
// Revision : 1.0 - initial release
// ============================================================================
module tb_aplic_msi_writer;

   logic        clk = 1'b0;
   logic        ni_rst;
   logic        i_msi_valid;
   logic        o_msi_ready;
   logic [31:0] i_msi_addr;
   logic [31:0] i_msi_data;
   logic        o_awvalid, i_awready;
   logic [31:0] o_awaddr;
   logic [3:0]  o_awid;
   logic [7:0]  o_awlen;
   logic [2:0]  o_awsize;
   logic [1:0]  o_awburst;
   logic        o_wvalid, i_wready;
   logic [63:0] o_wdata;
   logic [7:0]  o_wstrb;
   logic        o_wlast;
   logic        i_bvalid, o_bready;
   logic [1:0]  i_bresp;
   logic [2:0]  o_count;
   logic        o_busy;
   logic [7:0]  o_err_cnt;
   logic [31:0] o_err_addr;

   // B channel either answers immediately or is driven by hand
   logic b_auto, b_man;
   assign i_bvalid = b_auto ? o_bready : b_man;

   always #5 clk = ~clk;

   aplic_msi_writer #(.DEPTH(4), .ADDR_W(32), .AXI_ID_WIDTH(4), .AXI_ID(0)) dut (
      .i_clk(clk), .ni_rst(ni_rst),
      .i_msi_valid(i_msi_valid), .o_msi_ready(o_msi_ready),
      .i_msi_addr(i_msi_addr), .i_msi_data(i_msi_data),
      .o_awvalid(o_awvalid), .i_awready(i_awready), .o_awaddr(o_awaddr),
      .o_awid(o_awid), .o_awlen(o_awlen), .o_awsize(o_awsize), .o_awburst(o_awburst),
      .o_wvalid(o_wvalid), .i_wready(i_wready), .o_wdata(o_wdata),
      .o_wstrb(o_wstrb), .o_wlast(o_wlast),
      .i_bvalid(i_bvalid), .o_bready(o_bready), .i_bresp(i_bresp),
      .o_count(o_count), .o_busy(o_busy),
      .o_err_cnt(o_err_cnt), .o_err_addr(o_err_addr)
   );

   int tests = 0;
   int fails = 0;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Scoreboard: messages accepted by the DUT, in push order
   typedef struct { logic [31:0] addr; logic [31:0] data; } msg_t;
   msg_t sb_q[$];
   int aw_hs_n = 0, w_hs_n = 0, b_hs_n = 0;

   // Inputs change only just after posedge, so handshakes seen at negedge
   // are exactly those that complete on the following rising edge.
   always @(negedge clk) begin
      if (ni_rst) begin
         if (i_msi_valid && o_msi_ready) sb_q.push_back('{i_msi_addr, i_msi_data});
         if (o_awvalid && i_awready) begin
            aw_hs_n++;
            if (sb_q.size() == 0) check("aw_unexpected", 64'd1, 64'd0);
            else check("sb_awaddr", {32'd0, o_awaddr}, {32'd0, sb_q[0].addr});
         end
         if (o_wvalid && i_wready) begin
            w_hs_n++;
            if (sb_q.size() == 0) check("w_unexpected", 64'd1, 64'd0);
            else begin
               check("sb_wdata", o_wdata, {sb_q[0].data, sb_q[0].data});
               check("sb_wstrb", {56'd0, o_wstrb}, sb_q[0].addr[2] ? 64'hF0 : 64'h0F);
            end
         end
         if (i_bvalid && o_bready) begin
            b_hs_n++;
            if (sb_q.size() == 0) check("b_unexpected", 64'd1, 64'd0);
            else void'(sb_q.pop_front());
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_msi(input logic [31:0] a, input logic [31:0] d);
      bit ok;
      int n;
      i_msi_valid = 1'b1;
      i_msi_addr  = a;
      i_msi_data  = d;
      n = 0;
      do begin
         @(negedge clk);
         ok = o_msi_ready;
         tick();
         n++;
      end while (!ok && n < 50);
      i_msi_valid = 1'b0;
      if (!ok) check("push_timeout", 64'd0, 64'd1);
   endtask

   task automatic wait_idle(input int budget);
      int n;
      n = 0;
      while (o_busy && n < budget) begin
         tick();
         n++;
      end
      if (o_busy) check("idle_timeout", 64'd1, 64'd0);
   endtask

   task automatic wait_bready(input int budget);
      int n;
      n = 0;
      while (!o_bready && n < budget) begin
         tick();
         n++;
      end
      if (!o_bready) check("bready_timeout", 64'd0, 64'd1);
   endtask

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      logic [7:0]  exp_strb;
      logic [63:0] exp_wdata;
   } vec_t;

   vec_t vecs[4];

   initial begin
      int a0, w0, b0;
      vecs[0] = '{32'h2400_0000, 32'h0000_0005, 8'h0F, 64'h0000_0005_0000_0005};
      vecs[1] = '{32'h2400_1004, 32'h0000_00FF, 8'hF0, 64'h0000_00FF_0000_00FF};
      vecs[2] = '{32'h2400_2008, 32'hDEAD_BEEF, 8'h0F, 64'hDEAD_BEEF_DEAD_BEEF};
      vecs[3] = '{32'h2400_300C, 32'h1234_5678, 8'hF0, 64'h1234_5678_1234_5678};

      ni_rst = 1'b0; i_msi_valid = 1'b0; i_msi_addr = '0; i_msi_data = '0;
      i_awready = 1'b0; i_wready = 1'b0; b_auto = 1'b1; b_man = 1'b0; i_bresp = 2'b00;
      tick(); tick();
      ni_rst = 1'b1;
      tick();

      // Reset values
      check("rst_msi_ready", {63'd0, o_msi_ready}, 64'd1);
      check("rst_awvalid",   {63'd0, o_awvalid}, 64'd0);
      check("rst_wvalid",    {63'd0, o_wvalid}, 64'd0);
      check("rst_bready",    {63'd0, o_bready}, 64'd0);
      check("rst_count",     {61'd0, o_count}, 64'd0);
      check("rst_busy",      {63'd0, o_busy}, 64'd0);
      check("rst_awaddr",    {32'd0, o_awaddr}, 64'd0);
      check("rst_wdata",     o_wdata, 64'd0);
      check("rst_wstrb",     {56'd0, o_wstrb}, 64'd0);
      check("rst_err_cnt",   {56'd0, o_err_cnt}, 64'd0);
      check("rst_err_addr",  {32'd0, o_err_addr}, 64'd0);
      check("const_awlen",   {56'd0, o_awlen}, 64'd0);
      check("const_awsize",  {61'd0, o_awsize}, 64'd2);
      check("const_awburst", {62'd0, o_awburst}, 64'd1);
      check("const_wlast",   {63'd0, o_wlast}, 64'd1);
      check("const_awid",    {60'd0, o_awid}, 64'd0);

      // Single MSIs against an always-ready slave
      i_awready = 1'b1; i_wready = 1'b1; b_auto = 1'b1;
      for (int i = 0; i < 4; i++) begin
         push_msi(vecs[i].addr, vecs[i].data);
         check("vec_awvalid_lat", {63'd0, o_awvalid}, 64'd1);
         check("vec_wvalid_lat",  {63'd0, o_wvalid}, 64'd1);
         check("vec_awaddr",      {32'd0, o_awaddr}, {32'd0, vecs[i].addr});
         check("vec_wstrb",       {56'd0, o_wstrb}, {56'd0, vecs[i].exp_strb});
         check("vec_wdata",       o_wdata, vecs[i].exp_wdata);
         wait_idle(20);
         check("vec_count_end",   {61'd0, o_count}, 64'd0);
         check("vec_busy_end",    {63'd0, o_busy}, 64'd0);
      end

      // Fill the FIFO under AW/W back-pressure; 5th request must be held
      i_awready = 1'b0; i_wready = 1'b0;
      b0 = b_hs_n;
      for (int i = 0; i < 4; i++) push_msi(32'h2400_0100 + 32'(i * 4), 32'h10 + 32'(i));
      check("full_count", {61'd0, o_count}, 64'd4);
      check("full_ready", {63'd0, o_msi_ready}, 64'd0);
      i_msi_valid = 1'b1; i_msi_addr = 32'h2400_0200; i_msi_data = 32'h99;
      repeat (3) tick();
      check("held_count",   {61'd0, o_count}, 64'd4);
      check("held_awvalid", {63'd0, o_awvalid}, 64'd1);
      i_awready = 1'b1; i_wready = 1'b1;
      push_msi(32'h2400_0200, 32'h99);
      wait_idle(100);
      check("fill_b_count", 64'(b_hs_n - b0), 64'd5);
      check("fill_sb_empty", 64'(sb_q.size()), 64'd0);

      // AW accepted 3 cycles before W
      i_awready = 1'b0; i_wready = 1'b0;
      a0 = aw_hs_n; w0 = w_hs_n;
      push_msi(32'h2400_0300, 32'h21);
      i_awready = 1'b1;
      repeat (3) tick();
      check("awfirst_awvalid", {63'd0, o_awvalid}, 64'd0);
      check("awfirst_wvalid",  {63'd0, o_wvalid}, 64'd1);
      check("awfirst_bready",  {63'd0, o_bready}, 64'd0);
      i_wready = 1'b1;
      tick();
      check("awfirst_resp", {63'd0, o_bready}, 64'd1);
      i_awready = 1'b0; i_wready = 1'b0;
      wait_idle(10);
      check("awfirst_aw_hs", 64'(aw_hs_n - a0), 64'd1);
      check("awfirst_w_hs",  64'(w_hs_n - w0), 64'd1);

      // W accepted 3 cycles before AW
      a0 = aw_hs_n; w0 = w_hs_n;
      push_msi(32'h2400_0304, 32'h22);
      i_wready = 1'b1;
      repeat (3) tick();
      check("wfirst_wvalid",  {63'd0, o_wvalid}, 64'd0);
      check("wfirst_awvalid", {63'd0, o_awvalid}, 64'd1);
      check("wfirst_bready",  {63'd0, o_bready}, 64'd0);
      i_awready = 1'b1;
      tick();
      check("wfirst_resp", {63'd0, o_bready}, 64'd1);
      wait_idle(10);
      check("wfirst_aw_hs", 64'(aw_hs_n - a0), 64'd1);
      check("wfirst_w_hs",  64'(w_hs_n - w0), 64'd1);

      // Push and pop on the same edge at occupancy 2
      i_awready = 1'b1; i_wready = 1'b1; b_auto = 1'b0; b_man = 1'b0;
      push_msi(32'h2400_0400, 32'h31);
      push_msi(32'h2400_0404, 32'h32);
      wait_bready(10);
      check("pp_count_before", {61'd0, o_count}, 64'd2);
      b_man = 1'b1;
      i_msi_valid = 1'b1; i_msi_addr = 32'h2400_0408; i_msi_data = 32'h33;
      tick();
      i_msi_valid = 1'b0; b_man = 1'b0;
      check("pp_count_after", {61'd0, o_count}, 64'd2);
      b_auto = 1'b1;
      wait_idle(30);
      check("pp_sb_empty", 64'(sb_q.size()), 64'd0);

      // Error responses are dropped, not retried
      a0 = aw_hs_n;
      i_bresp = 2'b10;
      push_msi(32'h2400_0500, 32'h41);
      wait_idle(20);
      push_msi(32'h2400_0504, 32'h42);
      wait_idle(20);
      i_bresp = 2'b00;
      check("err_no_retry", 64'(aw_hs_n - a0), 64'd2);
`ifdef MSI_ERR_CNT_EN
      check("err_cnt",  {56'd0, o_err_cnt}, 64'd2);
      check("err_addr", {32'd0, o_err_addr}, 64'h2400_0504);
`else
      check("err_cnt",  {56'd0, o_err_cnt}, 64'd0);
      check("err_addr", {32'd0, o_err_addr}, 64'd0);
`endif

      // Reset while waiting in RESP with 3 queued
      b_auto = 1'b0; b_man = 1'b0;
      push_msi(32'h2400_0600, 32'h51);
      push_msi(32'h2400_0604, 32'h52);
      push_msi(32'h2400_0608, 32'h53);
      wait_bready(10);
      check("rr_count_before", {61'd0, o_count}, 64'd3);
      ni_rst = 1'b0;
      tick();
      ni_rst = 1'b1;
      sb_q.delete();
      check("rr_count",     {61'd0, o_count}, 64'd0);
      check("rr_awvalid",   {63'd0, o_awvalid}, 64'd0);
      check("rr_wvalid",    {63'd0, o_wvalid}, 64'd0);
      check("rr_bready",    {63'd0, o_bready}, 64'd0);
      check("rr_msi_ready", {63'd0, o_msi_ready}, 64'd1);
      check("rr_busy",      {63'd0, o_busy}, 64'd0);

      // Normal operation resumes after reset
      b_auto = 1'b1;
      push_msi(32'h2400_0700, 32'h61);
      wait_idle(20);
      check("post_rst_sb_empty", 64'(sb_q.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
